// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_pkg
// Description : Shared types and default constants for the rca_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

  localparam int RCA_WIDTH   = 32;
  localparam int RCA_NUM_REQ = 4;
  localparam int ID_W        = (RCA_NUM_REQ > 1) ? $clog2(RCA_NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } rca_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rca.sv
`default_nettype none
// ============================================================================
// Module      : rca
// Description : Parameterised ripple-carry adder, the shared datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module rca #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full adder per bit; the carry ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/rca_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rca_arbiter
// Description : Round-robin scheduler sharing one rca adder between NUM_REQ
//               requesters; returns WIDTH+1-bit sum plus requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_arbiter
  import rca_pkg::*;
#(
  parameter  int WIDTH   = RCA_WIDTH,
  parameter  int NUM_REQ = RCA_NUM_REQ,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  rca_arb_state_t state, next_state;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic             grant_vld;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] op_a, op_b;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH:0]   sum_q;
  logic             busy_q;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             accept;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int               idx;
    logic [ID_W-1:0]  sel;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!grant_vld && req_valid[sel]) begin
        grant     = sel;
        grant_vld = 1'b1;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the winner sees ready, and only while the adder is free.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  assign accept = (state == IDLE) && grant_vld;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_vld) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  rca #(.WIDTH(WIDTH)) u_rca (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand capture, pointer advance, result capture and registered busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      id_q   <= '0;
      sum_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        id_q   <= grant;
        rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      if (state == EXEC) sum_q <= {add_cout, add_sum};
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_arbiter
// Description : Self-checking bench for rca_arbiter against a transaction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_sum;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  always #5 clk = ~clk;

  rca_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Stimulus: per-requester pending request and its operands.
  bit         pend[N];
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];

  // Reference model: one in-flight transaction and its age in cycles.
  int         m_ptr;
  bit         m_has;
  int         m_age;
  int         m_id;
  logic [W:0] m_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_a[i*W +: W]      = pa[i];
      req_b[i*W +: W]      = pb[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 32'h8000_0000;
      default: return W'($urandom());
    endcase
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    w = winner();
    exp_rdy = '0;
    if (!m_has && w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_has && m_age >= 1));
    check("rsp_valid", 64'(rsp_valid), 64'(m_has && m_age >= 2));
    if (m_has && m_age >= 2) begin
      check("rsp_sum", 64'(rsp_sum), 64'(m_sum));
      check("rsp_id", 64'(rsp_id), 64'(m_id));
    end
    @(posedge clk);
    if (!m_has) begin
      if (w >= 0) begin
        m_has   = 1'b1;
        m_age   = 1;
        m_id    = w;
        m_sum   = {1'b0, pa[w]} + {1'b0, pb[w]};
        m_ptr   = (w + 1) % N;
        pend[w] = 1'b0;
      end
    end else if (m_age >= 2) begin
      if (rsp_ready) m_has = 1'b0;
    end else begin
      m_age++;
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    m_has = 1'b0;
    m_age = 0;
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    clear_reqs();
    m_has = 1'b0; m_age = 0; m_ptr = 0; m_id = 0; m_sum = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state with no requests.
    step();
    check("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);

    // Single request from requester 2: 5 + 7.
    pend[2] = 1'b1; pa[2] = 32'd5; pb[2] = 32'd7;
    repeat (4) step();

    // Carry-out from requester 0.
    do_reset();
    clear_reqs();
    pend[0] = 1'b1; pa[0] = 32'hFFFF_FFFF; pb[0] = 32'd1;
    repeat (4) step();

    // All four requesting continuously from reset.
    do_reset();
    clear_reqs();
    repeat (20) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin
          pend[i] = 1'b1; pa[i] = rand_op(); pb[i] = rand_op();
        end
      step();
    end

    // Response backpressure.
    do_reset();
    clear_reqs();
    pend[1] = 1'b1; pa[1] = 32'h1234_5678; pb[1] = 32'h0FED_CBA9;
    rsp_ready = 1'b0;
    pend[0] = 1'b0;
    repeat (2) step();
    pend[0] = 1'b1; pa[0] = 32'd3; pb[0] = 32'd4;
    repeat (5) step();
    rsp_ready = 1'b1;
    repeat (5) step();

    // Reset while in EXEC, then requester 3 alone.
    clear_reqs();
    step();
    pend[1] = 1'b1; pa[1] = 32'd100; pb[1] = 32'd200;
    step();
    do_reset();
    clear_reqs();
    pend[3] = 1'b1; pa[3] = 32'hDEAD_BEEF; pb[3] = 32'h1111_1111;
    repeat (4) step();

    // Round-robin skip: rr_ptr=1 with requesters 0 and 3 valid.
    do_reset();
    clear_reqs();
    pend[0] = 1'b1; pa[0] = 32'd1; pb[0] = 32'd2;
    repeat (4) step();
    pend[0] = 1'b1; pa[0] = 32'd10; pb[0] = 32'd20;
    pend[3] = 1'b1; pa[3] = 32'd30; pb[3] = 32'd40;
    repeat (8) step();

    // Randomized traffic with random backpressure and dropped requests.
    clear_reqs();
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1; pa[i] = rand_op(); pb[i] = rand_op();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rca_arbiter.md
# rca_arbiter

Round-robin scheduler that shares one `rca` adder instance between `NUM_REQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, registers the operands, and sequences the add through the shared ripple-carry datapath. It returns the `WIDTH+1`-bit sum with the requester ID over a single valid/ready response channel. It sits between the client blocks and the adder datapath, so clients never instantiate their own adder.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the sum is `WIDTH+1` bits.
- `NUM_REQ`, 4, number of requesters, minimum 2.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, reset, asynchronous and active-low.
- `req_valid`, input, `NUM_REQ`, per-requester request valid.
- `req_ready`, output, `NUM_REQ`, per-requester accept; at most one bit high.
- `req_a`, input, `NUM_REQ`×`WIDTH`, operand A per requester.
- `req_b`, input, `NUM_REQ`×`WIDTH`, operand B per requester.
- `rsp_valid`, output, 1, result available.
- `rsp_ready`, input, 1, consumer accepts result.
- `rsp_sum`, output, `WIDTH+1`, registered `a+b`.
- `rsp_id`, output, `ID_W`, index of the requester that owns the result.
- `busy`, output, 1, high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant the first requester with `req_valid` high, searching from `rr_ptr` upward modulo `NUM_REQ`.
  - `req_ready[grant]` is combinational from `req_valid` and `rr_ptr`, and is only ever high in IDLE.
  - On handshake:
    - Latch `req_a`/`req_b` of the granted requester into `op_a`/`op_b` and its index into `id_q`.
    - Set `rr_ptr` to `(grant+1) mod NUM_REQ`.
    - Go to EXEC.
  - With no valid request, stay in IDLE; `rr_ptr` is unchanged.
- **EXEC**
  - `op_a` and `op_b` drive the `rca` instance with carry-in 0.
  - The full `WIDTH+1`-bit output is captured into `sum_q`.
  - Unconditionally go to RESP.
- **RESP**
  - `rsp_valid` is high; `rsp_sum = sum_q`, `rsp_id = id_q`.
  - These outputs are held stable until `rsp_ready` is high.
  - On handshake, go to IDLE.
  - No new request is accepted in this state.
- Arithmetic:
  - Unsigned, no truncation.
  - The MSB of `rsp_sum` is the carry-out.
  - The maximum result is `2^(WIDTH+1)-2`.
- Fairness: a requester that keeps `req_valid` asserted is granted within `NUM_REQ` completed transactions.
- Simultaneous requests: only the round-robin winner is accepted. The others see `req_ready` low and must hold their request.
- A requester that drops `req_valid` before being granted is simply not granted. No state is kept per requester.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - State IDLE, `rr_ptr` 0, `op_a`/`op_b`/`sum_q`/`id_q` 0.
  - `rsp_valid` 0, `busy` 0.
  - `req_ready` is driven only by IDLE logic, so it is 0 unless a `req_valid` is high.
- Latency:
  - Request handshake in cycle T, EXEC in T+1, `rsp_valid` high in T+2.
  - With `rsp_ready` high in T+2, IDLE in T+3 and a new request can be accepted in T+3.
  - Peak throughput is one add per 3 cycles.
- Backpressure: `rsp_ready` low holds RESP indefinitely; `busy` stays high and all `req_ready` stay low.
- Reset mid-operation discards any in-flight operands or result. No response is produced for it, and the requester must re-issue.
- `busy` is registered: high from T+1 through the cycle of the response handshake.

## Structure
- Shared package `rca_pkg`:
  - state enum `rca_arb_state_t` (IDLE, EXEC, RESP);
  - default `WIDTH`/`NUM_REQ` constants;
  - `ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1`.
- One sub-module: the existing `rca` adder, instantiated once as the shared datapath.
- Round-robin grant logic stays inline as a combinational function of `req_valid` and `rr_ptr`.

## Test plan
- **Single request, immediate response:** reset, then `req_valid=4'b0100`, a=5, b=7 → `req_ready=4'b0100` in T, `rsp_valid` in T+2 with `rsp_sum=12`, `rsp_id=2`, `busy` high T+1..T+2.
- **Carry-out:** requester 0 with a=32'hFFFFFFFF, b=1 → `rsp_sum=33'h1_0000_0000`, `rsp_id=0`.
- **All four requesting continuously from reset:** grants in order 0,1,2,3,0; each response carries the matching `rsp_id` and sum.
- **Response backpressure:** hold `rsp_ready` low for 5 cycles in RESP → `rsp_valid`, `rsp_sum` and `rsp_id` stable, all `req_ready` low; release → IDLE the next cycle.
- **Reset in EXEC:** assert `rst_n=0` in T+1 → `rsp_valid` never rises, `rr_ptr` returns to 0, and the next request from requester 3 is granted and produces the correct sum.
- **Round-robin skip:** `rr_ptr=1` with `req_valid=4'b1001` → requester 3 is granted and `rr_ptr` becomes 0.
